// File: rtl/tod_clock_counter_pkg.sv
// Shared constants, field widths and the packed time-of-day record.
// Also holds the 24h -> 12h hour presentation helper.
// Imported by the interface, the wrap counter users and the top.
package tod_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } tod_t;

  // 24h hour to 12h presentation: 0 -> 12, 13..23 -> 1..11, others unchanged.
  function automatic logic [HOUR_W-1:0] hour_12h(input logic [HOUR_W-1:0] h);
    logic [HOUR_W-1:0] r;
    r = h;
    if (h == '0) begin
      r = HOUR_W'(12);
    end else if (h > HOUR_W'(12)) begin
      r = h - HOUR_W'(12);
    end
    return r;
  endfunction

endpackage

// File: rtl/tod_clock_counter_if.sv
// Control and time-of-day bus between a controller and tod_clock_counter.
// master drives run/set/mode (and alarm config); slave drives the time outputs.
// Alarm signals exist only when TOD_ALARM_EN is defined.
interface tod_clock_counter_if #(
  parameter int SUB_W = 26
) ();
  import tod_pkg::*;

  logic              en;
  logic              set_valid;
  logic [HOUR_W-1:0] set_hours;
  logic [MIN_W-1:0]  set_minutes;
  logic [SEC_W-1:0]  set_seconds;
  logic              mode_12h;
  logic [HOUR_W-1:0] hours;
  logic              pm;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [SUB_W-1:0]  subsec;
  logic              sec_tick;
  logic              day_tick;
  logic              set_err;
`ifdef TOD_ALARM_EN
  logic [HOUR_W-1:0] alarm_hours;
  logic [MIN_W-1:0]  alarm_minutes;
  logic              alarm_clr;
  logic              alarm_hit;

  modport master (
    output en, set_valid, set_hours, set_minutes, set_seconds, mode_12h,
    output alarm_hours, alarm_minutes, alarm_clr,
    input  hours, pm, minutes, seconds, subsec, sec_tick, day_tick, set_err,
    input  alarm_hit
  );

  modport slave (
    input  en, set_valid, set_hours, set_minutes, set_seconds, mode_12h,
    input  alarm_hours, alarm_minutes, alarm_clr,
    output hours, pm, minutes, seconds, subsec, sec_tick, day_tick, set_err,
    output alarm_hit
  );
`else
  modport master (
    output en, set_valid, set_hours, set_minutes, set_seconds, mode_12h,
    input  hours, pm, minutes, seconds, subsec, sec_tick, day_tick, set_err
  );

  modport slave (
    input  en, set_valid, set_hours, set_minutes, set_seconds, mode_12h,
    output hours, pm, minutes, seconds, subsec, sec_tick, day_tick, set_err
  );
`endif

endinterface

// File: rtl/tod_clock_counter_wrap.sv
// Modulo-(MAX+1) counter with load; carry flags an increment out of MAX.
// Latency: count updates on the edge after inc/load; carry is combinational.
// Load has priority over inc; no backpressure.
module tod_wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         carry
);

  assign carry = inc && (count == W'(MAX));

  // Load wins over increment; increment wraps MAX back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= carry ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tod_clock_counter.sv
// Time-of-day counter: sub-second cycle count cascading into hh:mm:ss, optional alarm (TOD_ALARM_EN).
// Latency: counts and tick/err pulses register on the edge after the cause; hours/pm decode is combinational.
// No backpressure: a set is accepted every cycle and overrides that cycle's increment.
module tod_clock_counter
  import tod_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int SUB_W  = $clog2(CLK_HZ)
) (
  input  logic               clk,
  input  logic               reset,
  tod_clock_counter_if.slave bus
);

  if (CLK_HZ < 2) begin : g_clk_hz_check
    $error("tod_clock_counter: CLK_HZ must be at least 2");
  end

  logic [SUB_W-1:0]  subsec;
  logic [SEC_W-1:0]  sec_cnt;
  logic [MIN_W-1:0]  min_cnt;
  logic [HOUR_W-1:0] hour_cnt;
  logic              set_ok;
  logic              sub_wrap;
  logic              sec_inc;
  logic              sec_carry;
  logic              min_carry;
  logic              hour_carry;
  logic              sec_tick;
  logic              day_tick;
  logic              set_err;
  tod_t              now;
  tod_t              load_val;

  // A set is only honoured when every field is in range.
  assign set_ok = bus.set_valid
               && (bus.set_hours   <= HOUR_W'(HOUR_MAX))
               && (bus.set_minutes <= MIN_W'(MIN_MAX))
               && (bus.set_seconds <= SEC_W'(SEC_MAX));

  assign sub_wrap = bus.en && (subsec == SUB_W'(CLK_HZ - 1));
  assign sec_inc  = sub_wrap && !set_ok;
  assign load_val = '{hour: bus.set_hours, min: bus.set_minutes, sec: bus.set_seconds};

  // Sub-second cycle counter; a valid set realigns the second boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      subsec <= '0;
    end else if (set_ok) begin
      subsec <= '0;
    end else if (bus.en) begin
      subsec <= sub_wrap ? '0 : subsec + 1'b1;
    end
  end

  tod_wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_inc),
    .load     (set_ok),
    .load_val (load_val.sec),
    .count    (sec_cnt),
    .carry    (sec_carry)
  );

  tod_wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_carry),
    .load     (set_ok),
    .load_val (load_val.min),
    .count    (min_cnt),
    .carry    (min_carry)
  );

  tod_wrap_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .inc      (min_carry),
    .load     (set_ok),
    .load_val (load_val.hour),
    .count    (hour_cnt),
    .carry    (hour_carry)
  );

  // One-cycle pulses, visible together with the counter values they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= sec_inc;
      day_tick <= hour_carry;
      set_err  <= bus.set_valid && !set_ok;
    end
  end

  assign now = '{hour: hour_cnt, min: min_cnt, sec: sec_cnt};

  assign bus.subsec   = subsec;
  assign bus.seconds  = now.sec;
  assign bus.minutes  = now.min;
  assign bus.hours    = bus.mode_12h ? hour_12h(now.hour) : now.hour;
  assign bus.pm       = (now.hour >= HOUR_W'(12));
  assign bus.sec_tick = sec_tick;
  assign bus.day_tick = day_tick;
  assign bus.set_err  = set_err;

`ifdef TOD_ALARM_EN
  logic [MIN_W-1:0]  min_next;
  logic [HOUR_W-1:0] hour_next;
  logic              alarm_fire;
  logic              alarm_hit;

  // Minute/hour values that take effect on the same edge as a seconds rollover.
  assign min_next   = min_carry ? '0 : min_cnt + 1'b1;
  assign hour_next  = hour_carry ? '0 : (min_carry ? hour_cnt + 1'b1 : hour_cnt);
  assign alarm_fire = sec_carry
                   && (min_next == bus.alarm_minutes)
                   && (hour_next == bus.alarm_hours);

  // Sticky alarm flag; a firing alarm beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_hit <= 1'b0;
    end else if (alarm_fire) begin
      alarm_hit <= 1'b1;
    end else if (bus.alarm_clr) begin
      alarm_hit <= 1'b0;
    end
  end

  assign bus.alarm_hit = alarm_hit;
`endif

endmodule

// File: tb/tb_tod_clock_counter.sv
// Self-checking bench for tod_clock_counter at CLK_HZ=4.
// Reference model keeps time as seconds-of-day plus a cycle count.
// Alarm checks are compiled in when TOD_ALARM_EN is defined.
module tb_tod_clock_counter;

  localparam int CLK_HZ = 4;
  localparam int SUB_W  = 2;
  localparam int DAY    = 86400;

  logic clk;
  logic reset;

  tod_clock_counter_if #(.SUB_W(SUB_W)) bus ();

  tod_clock_counter #(.CLK_HZ(CLK_HZ), .SUB_W(SUB_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total;
  int bad;

  // model state
  int m_t;
  int m_sub;
  int m_sec_tick;
  int m_day_tick;
  int m_set_err;
  int m_alarm_hit;
  int tick_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_sub = 0;
    m_sec_tick = 0; m_day_tick = 0; m_set_err = 0; m_alarm_hit = 0;
  endtask

  // Effect of one rising edge, computed from the inputs held during that cycle.
  task automatic model_edge();
    int sh, sm, ss;
    bit fire;
    sh = int'(bus.set_hours); sm = int'(bus.set_minutes); ss = int'(bus.set_seconds);
    fire = 0;
    m_sec_tick = 0; m_day_tick = 0; m_set_err = 0;
    if (bus.set_valid && sh <= 23 && sm <= 59 && ss <= 59) begin
      m_t = sh * 3600 + sm * 60 + ss;
      m_sub = 0;
    end else begin
      if (bus.set_valid) m_set_err = 1;
      if (bus.en) begin
        m_sub = m_sub + 1;
        if (m_sub == CLK_HZ) begin
          m_sub = 0;
          m_t = (m_t + 1) % DAY;
          m_sec_tick = 1;
          m_day_tick = (m_t == 0) ? 1 : 0;
`ifdef TOD_ALARM_EN
          if ((m_t % 60) == 0 &&
              (m_t / 60) == int'(bus.alarm_hours) * 60 + int'(bus.alarm_minutes))
            fire = 1;
`endif
        end
      end
    end
`ifdef TOD_ALARM_EN
    if (fire) m_alarm_hit = 1;
    else if (bus.alarm_clr) m_alarm_hit = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    int h24, hexp;
    h24  = m_t / 3600;
    hexp = bus.mode_12h ? ((h24 % 12 == 0) ? 12 : h24 % 12) : h24;
    check({tag, ".subsec"},   32'(bus.subsec),   32'(m_sub));
    check({tag, ".seconds"},  32'(bus.seconds),  32'(m_t % 60));
    check({tag, ".minutes"},  32'(bus.minutes),  32'((m_t / 60) % 60));
    check({tag, ".hours"},    32'(bus.hours),    32'(hexp));
    check({tag, ".pm"},       32'(bus.pm),       32'(h24 >= 12));
    check({tag, ".sec_tick"}, 32'(bus.sec_tick), 32'(m_sec_tick));
    check({tag, ".day_tick"}, 32'(bus.day_tick), 32'(m_day_tick));
    check({tag, ".set_err"},  32'(bus.set_err),  32'(m_set_err));
`ifdef TOD_ALARM_EN
    check({tag, ".alarm_hit"}, 32'(bus.alarm_hit), 32'(m_alarm_hit));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    if (bus.sec_tick === 1'b1) tick_seen++;
  endtask

  task automatic do_set(input string tag, input int h, input int m, input int s);
    bus.set_valid   = 1'b1;
    bus.set_hours   = 5'(h);
    bus.set_minutes = 6'(m);
    bus.set_seconds = 6'(s);
    step(tag);
    bus.set_valid   = 1'b0;
  endtask

  initial begin
    int hr_tab[3];
    int exp_h[3];
    int exp_pm[3];
    int n;
    total = 0; bad = 0; tick_seen = 0;
    hr_tab = '{0, 12, 13};
    exp_h  = '{12, 12, 1};
    exp_pm = '{0, 1, 1};

    bus.en = 1'b0; bus.set_valid = 1'b0; bus.mode_12h = 1'b0;
    bus.set_hours = '0; bus.set_minutes = '0; bus.set_seconds = '0;
`ifdef TOD_ALARM_EN
    bus.alarm_hours = 5'd7; bus.alarm_minutes = 6'd30; bus.alarm_clr = 1'b0;
`endif
    reset = 1'b1;
    model_reset();
    #2;
    check_all("reset24");
    bus.mode_12h = 1'b1;
    #1;
    check_all("reset12");
    check("reset12_hours", 32'(bus.hours), 32'd12);
    bus.mode_12h = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Eight enabled cycles -> two seconds.
    bus.en = 1'b1;
    tick_seen = 0;
    for (int i = 0; i < 8; i++) step("run8");
    check("run8_seconds", 32'(bus.seconds), 32'd2);
    check("run8_subsec", 32'(bus.subsec), 32'd0);
    check("run8_ticks", 32'(tick_seen), 32'd2);

    // Day rollover.
    do_set("set235959", 23, 59, 59);
    for (int i = 0; i < 4; i++) step("rollover");
    check("roll_day_tick", 32'(bus.day_tick), 32'd1);
    check("roll_sec_tick", 32'(bus.sec_tick), 32'd1);
    check("roll_hours", 32'(bus.hours), 32'd0);

    // Out-of-range set while frozen: error pulse only.
    bus.en = 1'b0;
    do_set("bad_set", 24, 0, 0);
    check("bad_set_err", 32'(bus.set_err), 32'd1);
    step("bad_set_after");
    check("bad_set_err_gone", 32'(bus.set_err), 32'd0);

    // Set coincident with the wrap cycle.
    bus.en = 1'b1;
    n = 0;
    while (m_sub != CLK_HZ - 1 && n < 8) begin
      step("to_wrap");
      n++;
    end
    check("reached_wrap", 32'(bus.subsec), 32'(CLK_HZ - 1));
    do_set("set_on_wrap", 10, 20, 30);
    check("wrap_set_no_tick", 32'(bus.sec_tick), 32'd0);
    check("wrap_set_sec", 32'(bus.seconds), 32'd30);

    // 12h decode.
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_set("mode_set", hr_tab[i], 5, 6);
      bus.mode_12h = 1'b1;
      #1;
      check("h12_hours", 32'(bus.hours), 32'(exp_h[i]));
      check("h12_pm", 32'(bus.pm), 32'(exp_pm[i]));
      bus.mode_12h = 1'b0;
      #1;
      check("h24_hours", 32'(bus.hours), 32'(hr_tab[i]));
    end

    // Freeze mid-second.
    bus.en = 1'b1;
    step("pre_freeze");
    step("pre_freeze");
    bus.en = 1'b0;
    tick_seen = 0;
    for (int i = 0; i < 10; i++) step("frozen");
    check("frozen_ticks", 32'(tick_seen), 32'd0);

    // Asynchronous reset mid-second.
    bus.en = 1'b1;
    step("pre_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("post_reset");

`ifdef TOD_ALARM_EN
    bus.alarm_hours = 5'd7; bus.alarm_minutes = 6'd30;
    do_set("alarm_set", 7, 29, 59);
    n = 0;
    while (m_t != 7 * 3600 + 30 * 60 && n < 8) begin
      step("alarm_run");
      n++;
    end
    check("alarm_hit_rise", 32'(bus.alarm_hit), 32'd1);
    for (int i = 0; i < 6; i++) step("alarm_hold");
    check("alarm_sticky", 32'(bus.alarm_hit), 32'd1);
    bus.alarm_clr = 1'b1;
    step("alarm_clr");
    bus.alarm_clr = 1'b0;
    check("alarm_cleared", 32'(bus.alarm_hit), 32'd0);
    do_set("alarm_direct", 7, 30, 0);
    for (int i = 0; i < 3; i++) step("alarm_direct_run");
    check("alarm_direct_low", 32'(bus.alarm_hit), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bus.en = ($urandom_range(0, 4) != 0);
      bus.mode_12h = $urandom_range(0, 1) == 1;
`ifdef TOD_ALARM_EN
      bus.alarm_clr = ($urandom_range(0, 7) == 0);
      bus.alarm_hours = 5'($urandom_range(0, 23));
      bus.alarm_minutes = 6'($urandom_range(0, 59));
`endif
      if ($urandom_range(0, 15) == 0) begin
        bus.set_valid = 1'b1;
        if (!bus.en && $urandom_range(0, 1) == 1) begin
          bus.set_hours   = 5'($urandom_range(0, 31));
          bus.set_minutes = 6'($urandom_range(0, 63));
          bus.set_seconds = 6'($urandom_range(0, 63));
        end else begin
          bus.set_hours   = 5'(($urandom_range(0, 1) == 1) ? 23 : $urandom_range(0, 23));
          bus.set_minutes = 6'(($urandom_range(0, 1) == 1) ? 59 : $urandom_range(0, 59));
          bus.set_seconds = 6'(($urandom_range(0, 1) == 1) ? 59 : $urandom_range(0, 59));
        end
      end else begin
        bus.set_valid = 1'b0;
      end
      step("random");
    end
    bus.set_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tod_clock_counter.md
TOD_CLOCK_COUNTER -- requirements
Module: tod_clock_counter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clk cycles per second; legal range >= 2.
REQ-002 Parameter SUB_W, default $clog2(CLK_HZ), width of the sub-second cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; low freezes all counters.
REQ-006 set_valid  input  1  one-cycle request to load set_hours/set_minutes/set_seconds.
REQ-007 set_hours / set_minutes / set_seconds  input  5 / 6 / 6  load value in 24h form.
REQ-008 mode_12h  input  1  selects 12h presentation on hours/pm.
REQ-009 hours  output  5  0-23 (24h mode) or 1-12 (12h mode).
REQ-010 pm  output  1  high when internal hour >= 12, in both modes.
REQ-011 minutes / seconds  output  6 / 6  0-59.
REQ-012 subsec  output  SUB_W  cycle count within the current second, 0..CLK_HZ-1.
REQ-013 sec_tick / day_tick / set_err  output  1 each  one-cycle pulses.

Function
REQ-014 The hour is held internally in 24h form; hours and pm are combinational decodes of it: 12h maps 0->12, 13-23->1-11.
REQ-015 With en=1, subsec increments every cycle and wraps CLK_HZ-1 -> 0.
REQ-016 On the wrap edge, seconds advances and sec_tick is high for the following cycle, the same cycle the new seconds value is visible.
REQ-017 Cascade: seconds 59->0 carries into minutes, minutes 59->0 into hours, and hours 23->0 pulses day_tick together with sec_tick.
REQ-018 With en=0, subsec/seconds/minutes/hours hold and no ticks are pulsed.
REQ-019 set_valid with set_hours<=23, set_minutes<=59 and set_seconds<=59 loads those values and clears subsec to 0 on the next edge, regardless of en.
REQ-020 A set takes priority over a same-cycle increment; no sec_tick or day_tick is generated for that cycle.
REQ-021 An out-of-range set changes no state and pulses set_err for exactly one cycle on the next edge.
REQ-022 Back-to-back set_valid is accepted every cycle; the last valid set wins.
REQ-023 A mode_12h change affects only the hours/pm decode, never the count.

Reset
REQ-024 Reset asynchronously forces subsec=0, seconds=0, minutes=0, internal hour=0 and all pulses to 0; hours therefore reads 0 in 24h mode and 12 in 12h mode.
REQ-025 Reset asserted mid-set or mid-carry discards the operation; counting resumes on the first edge after deassertion when en=1.

Configuration
REQ-026 Macro TOD_ALARM_EN compiles in the ports alarm_hours (input, 5), alarm_minutes (input, 6), alarm_clr (input, 1) and alarm_hit (output, 1).
REQ-027 With the macro defined, alarm_hit sets sticky on a natural increment into seconds=0 whose new hour:minute equals alarm_hours:alarm_minutes; a load via set never triggers it.
REQ-028 alarm_clr clears alarm_hit; a simultaneous alarm set and clear leaves alarm_hit high; reset clears alarm_hit.
REQ-029 Without the macro, the alarm ports and logic are absent and all other behaviour is identical.

Structure
REQ-030 Package tod_pkg holds the constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, the field widths, and a packed tod_t struct {hour, min, sec}.
REQ-031 Sub-module tod_wrap_counter (parameters MAX and W; inputs inc, load, load_val; outputs count, carry) is instantiated for seconds, minutes and hours.
REQ-032 A parameter check fails elaboration when CLK_HZ < 2.

Verification (CLK_HZ=4 unless stated)
REQ-033 Reset, then en=1 for 8 cycles -> seconds=2, subsec=0, exactly 2 sec_tick pulses.
REQ-034 Set 23:59:59, then run 4 cycles -> 00:00:00, with sec_tick and day_tick high in the same cycle.
REQ-035 Set 24:00:00 -> set_err pulses for one cycle, time unchanged; then set_valid coincident with the wrap cycle -> loaded value, no sec_tick.
REQ-036 mode_12h=1 at internal hours 0, 12 and 13 -> hours=12/pm=0, 12/1 and 1/1 respectively.
REQ-037 en=0 for 10 cycles mid-second -> all outputs are frozen; reset asserted mid-second -> all zero immediately, without waiting for a clk edge.
REQ-038 With TOD_ALARM_EN, alarm 07:30, set 07:29:59, run -> alarm_hit rises at 07:30:00 and stays high until alarm_clr; setting 07:30:00 directly leaves alarm_hit low.
